text_write_arbiter: RTL
=======================

Name: text_write_arbiter

Overview:
- Merges two character sources, PS/2 keyboard decoder and UART receiver, into the single write handshake of the 4x16 text buffer.
- Buffers each source in a small FIFO and round-robins between them.
- Drives the buffer's data_in/data_ready pair with a framed pulse: a high phase, then a mandatory low gap, so every character is seen exactly once by the buffer's level-edge handshake.

Parameters:
- DATA_W, 24: character/cell width.
- FIFO_DEPTH, 4: entries per source FIFO; power of 2, at least 2.
- HOLD_CYCLES, 2: cycles mem_data_ready is held high per character; at least 1.
- GAP_CYCLES, 2: cycles mem_data_ready is held low after each character; at least 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- kbd_data  in  DATA_W  keyboard character
- kbd_valid  in  1  keyboard beat valid
- kbd_ready  out  1  keyboard FIFO can accept
- uart_data  in  DATA_W  UART character
- uart_valid  in  1  UART beat valid
- uart_ready  out  1  UART FIFO can accept
- mem_data_in  out  DATA_W  character to text buffer
- mem_data_ready  out  1  write strobe to text buffer
- busy  out  1  FSM not in IDLE, or either FIFO non-empty
- grant_src  out  1  source of current/last character (0 = kbd, 1 = uart)

Behaviour:
- Reset values:
  - mem_data_ready = 0, mem_data_in = 0, grant_src = 1, busy = 0.
  - Both FIFOs empty; kbd_ready = uart_ready = 1; FSM in IDLE.
  - Reset is asynchronous and takes effect mid-pulse: strobe drops immediately and buffered characters are discarded.
- Source handshake:
  - Beat accepted on a rising edge with valid && ready.
  - ready = FIFO count < FIFO_DEPTH, combinational from count.
  - No bypass: a full FIFO that is popped in a cycle still shows ready = 0 in that cycle.
  - Simultaneous push and pop on the same FIFO is legal; count is unchanged.
- FSM states: IDLE, ASSERT, GAP.
  - IDLE: if either FIFO is non-empty, choose the source.
    - Only one non-empty: that source.
    - Both non-empty: the source != grant_src (round-robin), so kbd wins the first tie after reset.
    - Pop the chosen FIFO, register its head into mem_data_in, update grant_src, load the counter with HOLD_CYCLES-1, go to ASSERT.
    - If both FIFOs are empty, stay in IDLE.
  - ASSERT:
    - mem_data_ready = 1 and mem_data_in held stable.
    - When the counter reaches 0, load GAP_CYCLES-1 and go to GAP.
  - GAP:
    - mem_data_ready = 0; mem_data_in still held.
    - When the counter reaches 0, go to IDLE.
- Latency:
  - A beat accepted at edge t into an empty FIFO, with the FSM idle, raises mem_data_ready after edge t+2.
  - Minimum spacing between strobe rising edges is 1 + HOLD_CYCLES + GAP_CYCLES cycles.
- Ordering:
  - Per-source order is preserved.
  - Cross-source order follows arbitration only.
- Content: characters are passed unmodified, including 0x0D (CR) and 0x7F (BS), unless CRLF_FILTER_EN is defined; the buffer interprets them.
- Counter width: clog2 of max(HOLD_CYCLES, GAP_CYCLES), minimum 1 bit.

Optional Feature:
- Macro: CRLF_FILTER_EN.
- When defined, applies to the UART path only, at FIFO input:
  - A 0x0A accepted immediately after an accepted 0x0D (previous UART beat) completes its handshake but is not written to the FIFO.
  - A 0x0A not preceded by 0x0D is written as 0x0D.
  - The previous-was-CR flag clears on reset and on any non-0x0D beat.
- When undefined:
  - UART characters pass unchanged.
  - No extra state or logic is present.

Decomposition:
- Shared package text_pkg holds:
  - DATA_W default.
  - Constants CHAR_CR = 24'h0D, CHAR_LF = 24'h0A, CHAR_BS = 24'h7F.
  - State enum {IDLE, ASSERT, GAP}.
  - SRC_KBD = 0, SRC_UART = 1.
- Sub-module char_fifo, instantiated twice:
  - Parameterised by width and depth.
  - Interface: push/data/full, pop/head/empty, count.
  - Asynchronous reset.

Test Plan:
- Single kbd beat 24'h41 (defaults) -> mem_data_ready high for exactly 2 cycles starting 2 edges after accept, low for ≥2 cycles, mem_data_in = 24'h41 throughout; busy returns to 0.
- kbd and uart each push 3 beats in the same cycles (kbd 0x61,0x62,0x63; uart 0x31,0x32,0x33) -> strobe order 0x61,0x31,0x62,0x32,0x63,0x33; grant_src alternates 0,1,0,1,0,1.
- Hold kbd_valid high for 10 beats with FIFO_DEPTH=4 -> kbd_ready falls after 4 accepts (plus any already popped), no beat lost or duplicated, 10 strobes in order.
- Assert reset during ASSERT with 2 beats queued -> mem_data_ready drops without waiting for a clock, no further strobes after release, both ready = 1.
- With CRLF_FILTER_EN, uart sends 0x0D,0x0A,0x0A,0x41 -> strobes 0x0D,0x0D,0x41; without the macro -> 0x0D,0x0A,0x0A,0x41.
- HOLD_CYCLES=1, GAP_CYCLES=1, 3 kbd beats back-to-back -> strobe rising edges exactly 3 cycles apart.

Source files
------------

// File: rtl/text_pkg.sv
// text_pkg: shared constants, FSM states and source ids for the text buffer write path
// Contents: DATA_W_DEFAULT, CHAR_CR/LF/BS, state_t {IDLE, ASSERT, GAP}, SRC_KBD/SRC_UART.
package text_pkg;
   localparam int DATA_W_DEFAULT = 24;
   localparam logic [23:0] CHAR_CR = 24'h0D;
   localparam logic [23:0] CHAR_LF = 24'h0A;
   localparam logic [23:0] CHAR_BS = 24'h7F;
   typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, GAP = 2'd2} state_t;
   localparam logic SRC_KBD = 1'b0;
   localparam logic SRC_UART = 1'b1;
endpackage

// File: rtl/char_fifo.sv
// char_fifo: small synchronous FIFO holding characters from one source
// Ports: clk, reset (async, active-high); push/push_data/full on the write side;
//        pop/head/empty on the read side (head is the oldest entry); count = entries held.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module char_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   output logic                     full,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign full = count == DEPTH_CNT;
   assign empty = count == '0;
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign head = mem[rd_ptr];
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/text_write_arbiter.sv
// text_write_arbiter: merges keyboard and UART characters into framed writes to the text buffer
// Ports: clk, reset (async, active-high);
//        kbd_data/kbd_valid/kbd_ready and uart_data/uart_valid/uart_ready source handshakes;
//        mem_data_in/mem_data_ready framed write (HOLD_CYCLES high, then at least GAP_CYCLES low);
//        busy (engine active or characters queued); grant_src (0 = kbd, 1 = uart, last served).
// Build option: define CRLF_FILTER_EN to fold CR LF pairs and lone LF into CR on the UART path.
module text_write_arbiter
   import text_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEFAULT,
   parameter int FIFO_DEPTH  = 4,
   parameter int HOLD_CYCLES = 2,
   parameter int GAP_CYCLES  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] kbd_data,
   input  logic              kbd_valid,
   output logic              kbd_ready,
   input  logic [DATA_W-1:0] uart_data,
   input  logic              uart_valid,
   output logic              uart_ready,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_data_ready,
   output logic              busy,
   output logic              grant_src
);
   localparam int MAX_C = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CNT_W = $clog2(MAX_C) < 1 ? 1 : $clog2(MAX_C);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   state_t state;
   logic [CNT_W-1:0] cnt;
   logic [CW-1:0] kbd_count, uart_count;
   logic kbd_full, uart_full, kbd_empty, uart_empty;
   logic kbd_push, uart_push, kbd_pop, uart_pop, pick, sel;
   logic [DATA_W-1:0] kbd_head, uart_head, uart_push_data;
   assign kbd_ready = !kbd_full;
   assign uart_ready = !uart_full;
   assign kbd_push = kbd_valid && kbd_ready;
`ifdef CRLF_FILTER_EN
   logic prev_cr, uart_is_lf;
   assign uart_is_lf = uart_data == DATA_W'(CHAR_LF);
   // LF right after CR is consumed silently; any other LF becomes CR.
   assign uart_push = uart_valid && uart_ready && !(prev_cr && uart_is_lf);
   assign uart_push_data = uart_is_lf ? DATA_W'(CHAR_CR) : uart_data;
   always_ff @(posedge clk or posedge reset)
      if (reset) prev_cr <= 1'b0;
      else if (uart_valid && uart_ready) prev_cr <= uart_data == DATA_W'(CHAR_CR);
`else
   assign uart_push = uart_valid && uart_ready;
   assign uart_push_data = uart_data;
`endif
   char_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_kbd_fifo (
      .clk(clk), .reset(reset), .push(kbd_push), .push_data(kbd_data), .full(kbd_full),
      .pop(kbd_pop), .head(kbd_head), .empty(kbd_empty), .count(kbd_count)
   );
   char_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_uart_fifo (
      .clk(clk), .reset(reset), .push(uart_push), .push_data(uart_push_data), .full(uart_full),
      .pop(uart_pop), .head(uart_head), .empty(uart_empty), .count(uart_count)
   );
   // On a tie the source not served last wins, so kbd takes the first tie after reset.
   assign pick = state == IDLE && !(kbd_empty && uart_empty);
   assign sel = kbd_empty ? SRC_UART : uart_empty ? SRC_KBD : !grant_src;
   assign kbd_pop = pick && sel == SRC_KBD;
   assign uart_pop = pick && sel == SRC_UART;
   assign busy = state != IDLE || kbd_count != '0 || uart_count != '0;
   // The strobe is registered from the state, so it rises one cycle after the
   // character is latched and mem_data_in is already stable when it does.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         mem_data_in <= '0;
         mem_data_ready <= 1'b0;
         grant_src <= SRC_UART;
      end else begin
         mem_data_ready <= state == ASSERT;
         if (pick) begin
            state <= ASSERT;
            cnt <= CNT_W'(HOLD_CYCLES - 1);
            grant_src <= sel;
            mem_data_in <= sel ? uart_head : kbd_head;
         end else if (state == ASSERT && cnt == '0) begin
            state <= GAP;
            cnt <= CNT_W'(GAP_CYCLES - 1);
         end else if (state == GAP && cnt == '0) begin
            state <= IDLE;
         end else if (state != IDLE) begin
            cnt <= cnt - 1'b1;
         end
      end
endmodule
